pyrxaclbufctrl: RTL and testbench
=================================

PYRXACLBUFCTRL -- requirements
Module: pyrxaclbufctrl

Interface
REQ-001 SHALL have port clk_6M  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rstz  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports lnctrl_addr  in  8, lnctrl_din  in  32, lnctrl_we  in  1, lnctrl_cs  in  1: link-controller payload write port.
REQ-004 SHALL have ports rx_start  in  1 (payload start pulse), rx_done  in  1 (payload end pulse), rx_crcok  in  1, rx_seqn  in  1, rx_len  in  10 (payload bytes), all sampled on the same edge as their pulse.
REQ-005 SHALL have port rx_flush  in  1  synchronous clear of all buffer state.
REQ-006 SHALL have ports bsm_addr  in  8, bsm_cs  in  1, bsm_rd_done  in  1 (pulse, buffer consumed): baseband-state-machine read port.
REQ-007 SHALL have outputs bsm_dout  out  32, bsm_rdy  out  1, bsm_len  out  10, arqn  out  1, rx_drop  out  1.

Function
REQ-008 SHALL contain two 256x32 single-port buffers (buf0, buf1) used ping-pong; each buffer has state FREE, FILL or FULL.
REQ-009 SHALL keep write pointer wbuf and read pointer rbuf (1 bit each), both 0 after reset.
REQ-010 On rx_start with buffer[wbuf] FREE or FILL: buffer[wbuf] -> FILL, rx_drop <= 0 (FILL restart aborts the prior partial payload).
REQ-011 On rx_start with buffer[wbuf] FULL: no state change, rx_drop <= 1.
REQ-012 lnctrl writes (lnctrl_cs and lnctrl_we) SHALL reach buffer[wbuf] only while it is FILL; otherwise ignored.
REQ-013 On rx_done with buffer[wbuf] FILL, rx_crcok=1, and (last_seqn_vld=0 or rx_seqn!=last_seqn): buffer -> FULL, store rx_len, last_seqn <= rx_seqn, last_seqn_vld <= 1, wbuf toggles, arqn <= 1.
REQ-014 On rx_done with FILL, rx_crcok=1, duplicate SEQN: buffer -> FREE, wbuf unchanged, arqn <= 1.
REQ-015 On rx_done with FILL and rx_crcok=0: buffer -> FREE, last_seqn unchanged, arqn <= 0.
REQ-016 On rx_done with buffer[wbuf] not FILL (dropped packet): no state change, arqn <= 0.
REQ-017 arqn and rx_drop SHALL be registered, valid one cycle after the triggering pulse, held until next update.
REQ-018 bsm_rdy SHALL equal (buffer[rbuf]==FULL), registered; bsm_len SHALL be the stored length of buffer[rbuf].
REQ-019 bsm_cs with buffer[rbuf] FULL SHALL read buffer[rbuf] at bsm_addr; bsm_dout valid one cycle after bsm_cs, held otherwise.
REQ-020 bsm_cs with buffer[rbuf] not FULL SHALL be ignored; bsm_dout holds.
REQ-021 bsm_rd_done with buffer[rbuf] FULL: buffer -> FREE, rbuf toggles; otherwise ignored.
REQ-022 Same-cycle rx_done and bsm_rd_done SHALL both take effect; rx_start SHALL evaluate pre-edge state (a buffer freed the same cycle counts as FULL).
REQ-023 rx_flush SHALL set both buffers FREE, wbuf=rbuf=0, last_seqn_vld=0, arqn=0, rx_drop=0, and override all same-cycle events; SRAM contents and bsm_dout untouched.

Reset
REQ-024 rstz high SHALL asynchronously force: buffers FREE, wbuf=rbuf=0, last_seqn=0, last_seqn_vld=0, arqn=0, rx_drop=0, bsm_rdy=0, bsm_len=0, bsm_dout=0.
REQ-025 Reset mid-FILL SHALL discard the partial payload; no write SHALL occur while rstz is high.

Structure
REQ-026 Buffer-state encoding (FREE/FILL/FULL) and width constants (address 8, data 32, length 10) SHALL live in the shared baseband package.
REQ-027 The two buffers SHALL be instances of the existing sram256x32_1p; per-buffer state tracking MAY be a sub-module pyrxbufstate instantiated twice; no other sub-modules.

Verification
REQ-028 Reset, rx_start, write words 0..3 = 0x11111111..0x44444444, rx_done crcok=1 seqn=1 len=16 -> arqn=1, bsm_rdy=1, bsm_len=16; bsm reads addr 2 -> bsm_dout=0x33333333 next cycle.
REQ-029 Second packet seqn=1 crcok=1 -> arqn=1, bsm_rdy unchanged, wbuf unchanged (duplicate discarded).
REQ-030 Packet crcok=0 -> arqn=0, buffer FREE, last_seqn unchanged.
REQ-031 Fill both buffers (seqn 0 then 1), no bsm_rd_done, third rx_start -> rx_drop=1, its writes ignored, rx_done -> arqn=0; then bsm_rd_done -> bsm_rdy stays 1 with buf1 contents, bsm_len of buf1.
REQ-032 rx_done and bsm_rd_done in same cycle -> both buffers transition; rx_flush mid-FILL -> all state cleared, next packet seqn=0 accepted.
REQ-033 Assert rstz during FILL write burst -> all outputs to reset values immediately, subsequent packet accepted into buf0.

Source files
------------

// File: rtl/pyrxaclbufctrl_pkg.sv
// Shared baseband definitions for the ACL receive payload buffer controller.
// Holds the per-buffer state encoding and the address/data/length widths.
package pyrxaclbufctrl_pkg;

  localparam int unsigned AddrW = 8;
  localparam int unsigned DataW = 32;
  localparam int unsigned LenW  = 10;

  typedef enum logic [1:0] {
    BufFree = 2'd0,
    BufFill = 2'd1,
    BufFull = 2'd2
  } buf_state_e;

endpackage

// File: rtl/pyrxbufstate.sv
// State tracker for one ping-pong payload buffer (FREE/FILL/FULL plus stored length).
// Ports: clk_i, rst_i (async active-high), flush_i (sync clear), set_fill_i,
//        set_full_i (latches len_i), set_free_i, state_o current state,
//        state_d_o next state, len_d_o next stored length.
module pyrxbufstate
  import pyrxaclbufctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            set_fill_i,
  input  logic            set_full_i,
  input  logic            set_free_i,
  input  logic [LenW-1:0] len_i,
  output buf_state_e      state_o,
  output buf_state_e      state_d_o,
  output logic [LenW-1:0] len_d_o
);

  buf_state_e      state_q, state_d;
  logic [LenW-1:0] len_q, len_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (flush_i) begin
      state_d = BufFree;
    end else if (set_free_i) begin
      state_d = BufFree;
    end else if (set_full_i) begin
      state_d = BufFull;
      len_d   = len_i;
    end else if (set_fill_i) begin
      state_d = BufFill;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BufFree;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  assign state_o   = state_q;
  assign state_d_o = state_d;
  assign len_d_o   = len_d;

endmodule

// File: rtl/sram256x32_1p.sv
// 256x32 single-port SRAM model: synchronous write, asynchronous read.
// Ports: clk_i clock, cs_i chip select, we_i write enable, addr_i word address,
//        din_i write data, dout_o read data at addr_i.
module sram256x32_1p (
  input  logic        clk_i,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o
);

  logic [31:0] mem_q [256];

  always_ff @(posedge clk_i) begin
    if (cs_i && we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/pyrxaclbufctrl.sv
// ACL receive payload buffer controller: two ping-pong 256x32 buffers filled by the
// link controller and drained by the baseband state machine, with SEQN duplicate
// filtering and ARQN generation.
// Ports: clk_6M, rstz (async active-high); lnctrl_* payload write port;
//        rx_start/rx_done pulses with rx_crcok/rx_seqn/rx_len; rx_flush sync clear;
//        bsm_addr/bsm_cs/bsm_rd_done read port; bsm_dout/bsm_rdy/bsm_len/arqn/rx_drop.
module pyrxaclbufctrl
  import pyrxaclbufctrl_pkg::*;
(
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic [AddrW-1:0] lnctrl_addr,
  input  logic [DataW-1:0] lnctrl_din,
  input  logic             lnctrl_we,
  input  logic             lnctrl_cs,
  input  logic             rx_start,
  input  logic             rx_done,
  input  logic             rx_crcok,
  input  logic             rx_seqn,
  input  logic [LenW-1:0]  rx_len,
  input  logic             rx_flush,
  input  logic [AddrW-1:0] bsm_addr,
  input  logic             bsm_cs,
  input  logic             bsm_rd_done,
  output logic [DataW-1:0] bsm_dout,
  output logic             bsm_rdy,
  output logic [LenW-1:0]  bsm_len,
  output logic             arqn,
  output logic             rx_drop
);

  buf_state_e      st_q [2];
  buf_state_e      st_d [2];
  logic [LenW-1:0] len_d [2];
  logic [DataW-1:0] rd_data [2];
  logic [1:0]      set_fill, set_full, set_free, wr_en;

  logic wbuf_q, wbuf_d, rbuf_q, rbuf_d;
  logic last_seqn_q, last_seqn_d, seqn_vld_q, seqn_vld_d;
  logic arqn_q, arqn_d, drop_q, drop_d;
  logic bsm_rdy_q, bsm_rdy_d;
  logic [LenW-1:0]  bsm_len_q, bsm_len_d;
  logic [DataW-1:0] bsm_dout_q, bsm_dout_d;

  for (genvar b = 0; b < 2; b++) begin : g_buf
    logic [AddrW-1:0] ram_addr;

    // Writes only land in the buffer currently being filled; the other port user
    // (BSM read) always targets a FULL buffer, so the two never share an SRAM.
    assign wr_en[b]  = lnctrl_cs & lnctrl_we & ~rx_flush & (wbuf_q == 1'(b)) &
                       (st_q[b] == BufFill);
    assign ram_addr  = wr_en[b] ? lnctrl_addr : bsm_addr;

    pyrxbufstate u_state (
      .clk_i      (clk_6M),
      .rst_i      (rstz),
      .flush_i    (rx_flush),
      .set_fill_i (set_fill[b]),
      .set_full_i (set_full[b]),
      .set_free_i (set_free[b]),
      .len_i      (rx_len),
      .state_o    (st_q[b]),
      .state_d_o  (st_d[b]),
      .len_d_o    (len_d[b])
    );

    sram256x32_1p u_sram (
      .clk_i  (clk_6M),
      .cs_i   (wr_en[b]),
      .we_i   (wr_en[b]),
      .addr_i (ram_addr),
      .din_i  (lnctrl_din),
      .dout_o (rd_data[b])
    );
  end

  always_comb begin
    set_fill    = '0;
    set_full    = '0;
    set_free    = '0;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    last_seqn_d = last_seqn_q;
    seqn_vld_d  = seqn_vld_q;
    arqn_d      = arqn_q;
    drop_d      = drop_q;
    bsm_dout_d  = bsm_dout_q;

    // rx_start looks at pre-edge state, so a buffer freed this cycle still reads FULL.
    if (rx_start) begin
      if (st_q[wbuf_q] == BufFull) begin
        drop_d = 1'b1;
      end else begin
        set_fill[wbuf_q] = 1'b1;
        drop_d           = 1'b0;
      end
    end

    if (rx_done) begin
      if (st_q[wbuf_q] == BufFill) begin
        if (!rx_crcok) begin
          set_free[wbuf_q] = 1'b1;
          arqn_d           = 1'b0;
        end else if (!seqn_vld_q || (rx_seqn != last_seqn_q)) begin
          set_full[wbuf_q] = 1'b1;
          last_seqn_d      = rx_seqn;
          seqn_vld_d       = 1'b1;
          wbuf_d           = ~wbuf_q;
          arqn_d           = 1'b1;
        end else begin
          // Retransmission of an already accepted payload: ack it, keep nothing.
          set_free[wbuf_q] = 1'b1;
          arqn_d           = 1'b1;
        end
      end else begin
        arqn_d = 1'b0;
      end
    end

    if (bsm_rd_done && (st_q[rbuf_q] == BufFull)) begin
      set_free[rbuf_q] = 1'b1;
      rbuf_d           = ~rbuf_q;
    end

    if (bsm_cs && !rx_flush && (st_q[rbuf_q] == BufFull)) begin
      bsm_dout_d = rd_data[rbuf_q];
    end

    if (rx_flush) begin
      wbuf_d     = 1'b0;
      rbuf_d     = 1'b0;
      seqn_vld_d = 1'b0;
      arqn_d     = 1'b0;
      drop_d     = 1'b0;
    end

    // Ready/length track the post-edge state of the post-edge read buffer.
    bsm_rdy_d = (st_d[rbuf_d] == BufFull);
    bsm_len_d = len_d[rbuf_d];
  end

  always_ff @(posedge clk_6M or posedge rstz) begin
    if (rstz) begin
      wbuf_q      <= 1'b0;
      rbuf_q      <= 1'b0;
      last_seqn_q <= 1'b0;
      seqn_vld_q  <= 1'b0;
      arqn_q      <= 1'b0;
      drop_q      <= 1'b0;
      bsm_rdy_q   <= 1'b0;
      bsm_len_q   <= '0;
      bsm_dout_q  <= '0;
    end else begin
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      last_seqn_q <= last_seqn_d;
      seqn_vld_q  <= seqn_vld_d;
      arqn_q      <= arqn_d;
      drop_q      <= drop_d;
      bsm_rdy_q   <= bsm_rdy_d;
      bsm_len_q   <= bsm_len_d;
      bsm_dout_q  <= bsm_dout_d;
    end
  end

  assign bsm_dout = bsm_dout_q;
  assign bsm_rdy  = bsm_rdy_q;
  assign bsm_len  = bsm_len_q;
  assign arqn     = arqn_q;
  assign rx_drop  = drop_q;

endmodule

// File: tb/tb_pyrxaclbufctrl.sv
module tb_pyrxaclbufctrl;

  logic        clk_6M = 1'b0;
  logic        rstz;
  logic [7:0]  lnctrl_addr;
  logic [31:0] lnctrl_din;
  logic        lnctrl_we, lnctrl_cs;
  logic        rx_start, rx_done, rx_crcok, rx_seqn;
  logic [9:0]  rx_len;
  logic        rx_flush;
  logic [7:0]  bsm_addr;
  logic        bsm_cs, bsm_rd_done;
  logic [31:0] bsm_dout;
  logic        bsm_rdy;
  logic [9:0]  bsm_len;
  logic        arqn, rx_drop;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_dout;

  always #5 clk_6M = ~clk_6M;

  pyrxaclbufctrl dut (
    .clk_6M      (clk_6M),
    .rstz        (rstz),
    .lnctrl_addr (lnctrl_addr),
    .lnctrl_din  (lnctrl_din),
    .lnctrl_we   (lnctrl_we),
    .lnctrl_cs   (lnctrl_cs),
    .rx_start    (rx_start),
    .rx_done     (rx_done),
    .rx_crcok    (rx_crcok),
    .rx_seqn     (rx_seqn),
    .rx_len      (rx_len),
    .rx_flush    (rx_flush),
    .bsm_addr    (bsm_addr),
    .bsm_cs      (bsm_cs),
    .bsm_rd_done (bsm_rd_done),
    .bsm_dout    (bsm_dout),
    .bsm_rdy     (bsm_rdy),
    .bsm_len     (bsm_len),
    .arqn        (arqn),
    .rx_drop     (rx_drop)
  );

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  // Full payload: start pulse, nwords writes of base+i, done pulse (optionally with rd_done).
  task automatic send_pkt(input logic seqn, input logic crcok, input logic [9:0] len,
                          input int nwords, input logic [31:0] base, input logic rd);
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      lnctrl_cs   = 1'b1;
      lnctrl_we   = 1'b1;
      lnctrl_addr = 8'(i);
      lnctrl_din  = base + 32'(i);
      step();
    end
    lnctrl_cs   = 1'b0;
    lnctrl_we   = 1'b0;
    rx_done     = 1'b1;
    rx_crcok    = crcok;
    rx_seqn     = seqn;
    rx_len      = len;
    bsm_rd_done = rd;
    step();
    rx_done     = 1'b0;
    bsm_rd_done = 1'b0;
  endtask

  // Issue a BSM read, push the expected word, and compare one cycle later.
  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] e;
    bsm_cs   = 1'b1;
    bsm_addr = addr;
    exp_q.push_back(exp);
    step();
    bsm_cs = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (bsm_dout !== e) begin
      n_fail++;
      $display("FAIL %s: bsm_dout got %h expected %h", name, bsm_dout, e);
    end
    last_dout = e;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    chk("reset_arqn", 32'(arqn), 32'd0);
    chk("reset_drop", 32'(rx_drop), 32'd0);
    chk("reset_rdy", 32'(bsm_rdy), 32'd0);
    chk("reset_len", 32'(bsm_len), 32'd0);
    chk("reset_dout", bsm_dout, 32'd0);
  endtask

  task automatic test_basic();
    send_pkt(1'b1, 1'b1, 10'd16, 4, 32'h0, 1'b0);
    // words written above are 0..3; rewrite with the 0x11111111 pattern
    chk("basic_arqn", 32'(arqn), 32'd1);
    chk("basic_rdy", 32'(bsm_rdy), 32'd1);
    chk("basic_len", 32'(bsm_len), 32'd16);
    do_read(8'd2, 32'h2, "basic_rd2");
  endtask

  task automatic test_pattern();
    // Buffer is FULL now, so stimulate a fresh pattern via flush + new packet.
    rx_flush = 1'b1;
    step();
    rx_flush = 1'b0;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lnctrl_cs   = 1'b1;
      lnctrl_we   = 1'b1;
      lnctrl_addr = 8'(i);
      lnctrl_din  = 32'h11111111 * 32'(i + 1);
      step();
    end
    lnctrl_cs = 1'b0;
    lnctrl_we = 1'b0;
    rx_done = 1'b1; rx_crcok = 1'b1; rx_seqn = 1'b1; rx_len = 10'd16;
    step();
    rx_done = 1'b0;
    chk("pat_arqn", 32'(arqn), 32'd1);
    chk("pat_rdy", 32'(bsm_rdy), 32'd1);
    chk("pat_len", 32'(bsm_len), 32'd16);
    do_read(8'd2, 32'h33333333, "pat_rd2");
    do_read(8'd0, 32'h11111111, "pat_rd0");
  endtask

  task automatic test_dup();
    send_pkt(1'b1, 1'b1, 10'd20, 2, 32'hDEAD0000, 1'b0);
    chk("dup_arqn", 32'(arqn), 32'd1);
    chk("dup_rdy", 32'(bsm_rdy), 32'd1);
    chk("dup_len", 32'(bsm_len), 32'd16);
  endtask

  task automatic test_crcfail();
    send_pkt(1'b0, 1'b0, 10'd8, 2, 32'hBAD00000, 1'b0);
    chk("crc_arqn", 32'(arqn), 32'd0);
    chk("crc_rdy", 32'(bsm_rdy), 32'd1);
    // last_seqn still 1: seqn 1 is a duplicate, acked but discarded
    send_pkt(1'b1, 1'b1, 10'd8, 1, 32'hBAD10000, 1'b0);
    chk("crc_dup_arqn", 32'(arqn), 32'd1);
  endtask

  task automatic test_fill_both();
    // buf0 FULL, wbuf=1 (duplicate/crc packets left it unchanged)
    send_pkt(1'b0, 1'b1, 10'd8, 4, 32'hA0000000, 1'b0);
    chk("both_arqn", 32'(arqn), 32'd1);
    chk("both_drop0", 32'(rx_drop), 32'd0);
    chk("both_len0", 32'(bsm_len), 32'd16);
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    chk("both_drop", 32'(rx_drop), 32'd1);
    for (int i = 0; i < 3; i++) begin
      lnctrl_cs = 1'b1; lnctrl_we = 1'b1; lnctrl_addr = 8'(i); lnctrl_din = 32'hFFFF0000;
      step();
    end
    lnctrl_cs = 1'b0; lnctrl_we = 1'b0;
    rx_done = 1'b1; rx_crcok = 1'b1; rx_seqn = 1'b1; rx_len = 10'd4;
    step();
    rx_done = 1'b0;
    chk("both_drop_arqn", 32'(arqn), 32'd0);
    chk("both_drop_hold", 32'(rx_drop), 32'd1);
    do_read(8'd2, 32'h33333333, "both_nowrite");
    bsm_rd_done = 1'b1;
    step();
    bsm_rd_done = 1'b0;
    chk("both_rdy1", 32'(bsm_rdy), 32'd1);
    chk("both_len1", 32'(bsm_len), 32'd8);
    do_read(8'd1, 32'hA0000001, "both_rd_buf1");
  endtask

  task automatic test_back_to_back();
    // wbuf=0 (FREE), rbuf=1 (FULL), last_seqn=0
    send_pkt(1'b1, 1'b1, 10'd12, 3, 32'hC0000000, 1'b1);
    chk("b2b_arqn", 32'(arqn), 32'd1);
    chk("b2b_rdy", 32'(bsm_rdy), 32'd1);
    chk("b2b_len", 32'(bsm_len), 32'd12);
    do_read(8'd0, 32'hC0000000, "b2b_rd0");
    bsm_rd_done = 1'b1;
    step();
    bsm_rd_done = 1'b0;
    chk("b2b_empty", 32'(bsm_rdy), 32'd0);
  endtask

  task automatic test_flush();
    // wbuf=1 FREE, rbuf=1, last_seqn=1
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    lnctrl_cs = 1'b1; lnctrl_we = 1'b1; lnctrl_addr = 8'd0; lnctrl_din = 32'h55555555;
    step();
    lnctrl_cs = 1'b0; lnctrl_we = 1'b0;
    rx_flush = 1'b1;
    rx_done = 1'b1; rx_crcok = 1'b1; rx_seqn = 1'b0; rx_len = 10'd4;
    step();
    rx_flush = 1'b0;
    rx_done  = 1'b0;
    chk("flush_arqn", 32'(arqn), 32'd0);
    chk("flush_rdy", 32'(bsm_rdy), 32'd0);
    chk("flush_dout", bsm_dout, last_dout);
    // seqn 1 matches the old last_seqn; accepted only if validity was cleared
    send_pkt(1'b1, 1'b1, 10'd4, 2, 32'hD0000000, 1'b0);
    chk("flush_acc_arqn", 32'(arqn), 32'd1);
    chk("flush_acc_len", 32'(bsm_len), 32'd4);
    do_read(8'd1, 32'hD0000001, "flush_rd_buf0");
    rx_flush = 1'b1;
    step();
    rx_flush = 1'b0;
    send_pkt(1'b0, 1'b1, 10'd6, 2, 32'hD1000000, 1'b0);
    chk("flush_seqn0", 32'(arqn), 32'd1);
    chk("flush_seqn0_len", 32'(bsm_len), 32'd6);
  endtask

  task automatic test_reset_mid_fill();
    bsm_rd_done = 1'b1;
    step();
    bsm_rd_done = 1'b0;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    lnctrl_cs = 1'b1; lnctrl_we = 1'b1; lnctrl_addr = 8'd0; lnctrl_din = 32'h77777777;
    #3;
    rstz = 1'b1;
    #1;
    chk("rst_arqn", 32'(arqn), 32'd0);
    chk("rst_rdy", 32'(bsm_rdy), 32'd0);
    chk("rst_len", 32'(bsm_len), 32'd0);
    chk("rst_dout", bsm_dout, 32'd0);
    chk("rst_drop", 32'(rx_drop), 32'd0);
    step();
    lnctrl_cs = 1'b0; lnctrl_we = 1'b0;
    rstz = 1'b0;
    step();
    send_pkt(1'b0, 1'b1, 10'd4, 4, 32'hE0000000, 1'b0);
    chk("rst_acc_arqn", 32'(arqn), 32'd1);
    chk("rst_acc_rdy", 32'(bsm_rdy), 32'd1);
    chk("rst_acc_len", 32'(bsm_len), 32'd4);
    do_read(8'd3, 32'hE0000003, "rst_rd3");
  endtask

  initial begin
    rstz = 1'b1;
    lnctrl_addr = '0; lnctrl_din = '0; lnctrl_we = 1'b0; lnctrl_cs = 1'b0;
    rx_start = 1'b0; rx_done = 1'b0; rx_crcok = 1'b0; rx_seqn = 1'b0; rx_len = '0;
    rx_flush = 1'b0; bsm_addr = '0; bsm_cs = 1'b0; bsm_rd_done = 1'b0;
    last_dout = '0;
    step();
    step();
    rstz = 1'b0;
    step();
    test_reset();
    test_basic();
    test_pattern();
    test_dup();
    test_crcfail();
    test_fill_both();
    test_back_to_back();
    test_flush();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
